// File: rtl/wave_pkg.sv
// Shared definitions for the wave_meter block: FSM state encoding and
// default widths used by the top level and the hysteresis comparator.
package wave_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_LOW    = 2'd1,
        ST_HIGH   = 2'd2
    } wave_state_t;

endpackage

// File: rtl/wave_hyst_cmp.sv
// Hysteresis comparator: builds the lower/upper switching levels around
// thresh (clamped to the sample range) and classifies the current sample.
module wave_hyst_cmp
    import wave_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int HYST   = 16
) (
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] thresh,
    output logic              is_low,
    output logic              is_high
);

    // One extra bit so both the subtraction underflow and the addition
    // overflow can be detected without wrapping.
    localparam logic [DATA_W:0] HYST_V = (DATA_W+1)'(HYST);

    logic [DATA_W:0]   hi_sum;
    logic [DATA_W-1:0] lo;
    logic [DATA_W-1:0] hi;

    // Saturating band edges and the two compares against the sample.
    always_comb begin
        hi_sum  = {1'b0, thresh} + HYST_V;
        hi      = hi_sum[DATA_W] ? {DATA_W{1'b1}} : hi_sum[DATA_W-1:0];
        lo      = ({1'b0, thresh} >= HYST_V) ? (thresh - HYST_V[DATA_W-1:0]) : '0;
        is_low  = (sample <= lo);
        is_high = (sample >= hi);
    end

endmodule

// File: rtl/wave_meter.sv
// Period and min/max meter for a periodic waveform. A hysteresis FSM
// detects rising crossings of thresh; the samples between consecutive
// rising events form one measured cycle.
// Optional feature: define WAVE_METER_SUM_EN to add the wave_sum output
// (sum of the samples in each measured cycle).
module wave_meter
    import wave_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int HYST   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sample_en,
    input  logic [DATA_W-1:0]       wave_in,
    input  logic [DATA_W-1:0]       thresh,
    output logic                    meas_valid,
    output logic [CNT_W-1:0]        period,
    output logic [DATA_W-1:0]       wave_min,
    output logic [DATA_W-1:0]       wave_max,
    output logic                    timeout
`ifdef WAVE_METER_SUM_EN
    ,
    output logic [CNT_W+DATA_W-1:0] wave_sum
`endif
);

    // Count value one below saturation: an accepted sample seen while the
    // count sits here would push it to all-ones, which ends the window.
    localparam logic [CNT_W-1:0] CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

    wave_state_t       state_q;
    wave_state_t       next_state;
    logic              is_low;
    logic              is_high;
    logic              rise;
    logic              sat;
    logic              emit;
    logic              started_q;
    logic [CNT_W-1:0]  count_q;
    logic [DATA_W-1:0] win_min_q;
    logic [DATA_W-1:0] win_max_q;

    wave_hyst_cmp #(
        .DATA_W (DATA_W),
        .HYST   (HYST)
    ) u_cmp (
        .sample  (wave_in),
        .thresh  (thresh),
        .is_low  (is_low),
        .is_high (is_high)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_SEARCH;
        end else begin
            state_q <= next_state;
        end
    end

    // Next state, rising-event and saturation decode; saturation overrides
    // a coincident rising event and sends the FSM back to SEARCH.
    always_comb begin
        next_state = state_q;
        rise       = 1'b0;
        sat        = 1'b0;
        if (sample_en) begin
            case (state_q)
                ST_SEARCH: if (is_low) next_state = ST_LOW;
                ST_LOW: begin
                    if (is_high) begin
                        next_state = ST_HIGH;
                        rise       = 1'b1;
                    end
                end
                ST_HIGH:   if (is_low) next_state = ST_LOW;
                default:   next_state = ST_SEARCH;
            endcase
            if (started_q && (count_q == CNT_LAST)) begin
                sat        = 1'b1;
                next_state = ST_SEARCH;
            end
        end
        emit = rise && started_q && !sat;
    end

    // Window counting, min/max tracking and registered measurement outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q  <= 1'b0;
            count_q    <= '0;
            win_min_q  <= '0;
            win_max_q  <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            period     <= '0;
            wave_min   <= '0;
            wave_max   <= '0;
        end else begin
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            if (sat) begin
                timeout   <= 1'b1;
                started_q <= 1'b0;
                count_q   <= '0;
            end else if (sample_en && rise) begin
                if (emit) begin
                    meas_valid <= 1'b1;
                    period     <= count_q;
                    wave_min   <= win_min_q;
                    wave_max   <= win_max_q;
                end
                started_q <= 1'b1;
                count_q   <= CNT_W'(1);
                win_min_q <= wave_in;
                win_max_q <= wave_in;
            end else if (sample_en && started_q) begin
                count_q <= count_q + CNT_W'(1);
                if (wave_in < win_min_q) win_min_q <= wave_in;
                if (wave_in > win_max_q) win_max_q <= wave_in;
            end
        end
    end

`ifdef WAVE_METER_SUM_EN
    logic [CNT_W+DATA_W-1:0] acc_q;

    // Running sum of the current window, captured alongside period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            wave_sum <= '0;
        end else if (sat) begin
            acc_q <= '0;
        end else if (sample_en && rise) begin
            if (emit) wave_sum <= acc_q;
            acc_q <= {{CNT_W{1'b0}}, wave_in};
        end else if (sample_en && started_q) begin
            acc_q <= acc_q + {{CNT_W{1'b0}}, wave_in};
        end
    end
`endif

endmodule

// File: doc/wave_meter.md
WAVE_METER -- requirements
Module: wave_meter

Interface
REQ-001 SHALL have parameter DATA_W, default 12, sample width.
REQ-002 SHALL have parameter CNT_W, default 16, period counter width.
REQ-003 SHALL have parameter HYST, default 16, hysteresis half-band in LSBs.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port sample_en, input, 1, qualifies wave_in this cycle.
REQ-007 SHALL have port wave_in, input, DATA_W, unsigned sample from the upstream wave generator.
REQ-008 SHALL have port thresh, input, DATA_W, unsigned crossing threshold, quasi-static.
REQ-009 SHALL have port meas_valid, output, 1, one-cycle strobe that qualifies the measurement outputs.
REQ-010 SHALL have port period, output, CNT_W, accepted samples per cycle.
REQ-011 SHALL have port wave_min, output, DATA_W, minimum sample of the measured cycle.
REQ-012 SHALL have port wave_max, output, DATA_W, maximum sample of the measured cycle.
REQ-013 SHALL have port timeout, output, 1, one-cycle strobe raised on counter saturation.

Function
REQ-014 SHALL compute lo = thresh-HYST, saturating at 0, and hi = thresh+HYST, saturating at 2^DATA_W-1.
REQ-015 SHALL implement FSM SEARCH/LOW/HIGH with these transitions: SEARCH->LOW on wave_in<=lo; LOW->HIGH on wave_in>=hi; HIGH->LOW on wave_in<=lo.
REQ-016 SHALL evaluate transitions, counting and min/max updates only on cycles with sample_en=1; with sample_en=0, all state holds.
REQ-017 SHALL treat LOW->HIGH as a rising event; the first rising event after SEARCH sets started=1, count=1, min=max=wave_in, and emits nothing.
REQ-018 SHALL, on each later rising event, register period=count, wave_min/wave_max over the window from the previous event sample (inclusive) to the current sample (exclusive), and assert meas_valid the following cycle.
REQ-019 SHALL, on the same rising event, restart the window with count=1 and min=max=current sample.
REQ-020 SHALL, while started, increment count on each accepted non-event sample and update min/max.
REQ-021 SHALL, when count reaches 2^CNT_W-1 without an event, pulse timeout for one cycle, clear started and return to SEARCH; no meas_valid is produced.
REQ-022 SHALL hold period/wave_min/wave_max stable between meas_valid strobes.
REQ-023 SHALL give timeout priority if a rising event and saturation coincide.

Reset
REQ-024 SHALL, with rst_n low, immediately force FSM=SEARCH, started=0, count=0, meas_valid=0, timeout=0, period=0, wave_min=0, wave_max=0.
REQ-025 SHALL discard any in-progress window when reset is asserted mid-measurement; the first output after release needs two fresh rising events.

Configuration
REQ-026 SHALL, with WAVE_METER_SUM_EN defined, add output wave_sum (CNT_W+DATA_W bits): the sum of window samples, registered and strobed with meas_valid, reset to 0.
REQ-027 SHALL, without WAVE_METER_SUM_EN, have neither the wave_sum port nor the accumulator.

Structure
REQ-028 SHALL place the FSM state enum and the default DATA_W/CNT_W constants in the shared package wave_pkg.
REQ-029 SHALL implement the saturating lo/hi computation and compare logic in sub-module wave_hyst_cmp, with outputs is_low and is_high.

Verification
REQ-030 SHALL verify: square wave of 50 samples at 0 then 50 at 4000, thresh=2048 -> meas_valid after the second rising edge with period=100, wave_min=0, wave_max=4000.
REQ-031 SHALL verify: square wave with ±10 noise around 2048 superimposed at the transitions -> no extra events; period stays 100.
REQ-032 SHALL verify: constant 2048 -> stays in SEARCH, no meas_valid and no timeout; constant 0 after one rising event -> timeout after 65535 accepted samples.
REQ-033 SHALL verify: same wave with sample_en=1 every other cycle -> period=100, not 200.
REQ-034 SHALL verify: rst_n pulsed low mid-cycle -> outputs are 0 immediately; the next meas_valid arrives only after two rising events.
REQ-035 SHALL verify: with WAVE_METER_SUM_EN defined, a 4-sample cycle 0,0,4000,4000 -> wave_sum=8000.
